mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master arbiter and access sequencer for the single shared `Memory` port of the multicycle core. It arbitrates between the core (fetch/load/store, driven by the control unit's MemRead/MemWrite) and an external program-loader/debug port. It holds the memory strobes for a fixed access latency, returns read data with a one-cycle done pulse, and asserts a stall that the control unit uses to freeze its state while the core waits.

## Interface
Parameters:
- `ADDR_W`, 64, address width (matches `endereco`)
- `DATA_W`, 64, data width (matches `read_data`/`write_data`)
- `MEM_LAT`, 1, cycles the memory strobes are held per access; legal range 1..15
- `STARVE_MAX`, 8, consecutive loader losses before the loader is forced through; legal range 1..255; only used when `MEM_ARB_STARVE_EN` is defined

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low (0 = reset)
- `core_req`  in  1  core requests an access (MemRead | MemWrite)
- `core_we`  in  1  1 = write, 0 = read
- `core_addr`  in  ADDR_W  core address
- `core_wdata`  in  DATA_W  core write data
- `core_rdata`  out  DATA_W  registered read data for core
- `core_done`  out  1  one-cycle completion pulse for core
- `core_stall`  out  1  core must hold state
- `ld_req`, `ld_we`, `ld_addr`, `ld_wdata`  in  1/1/ADDR_W/DATA_W  loader request, same meaning as core
- `ld_gnt`  out  1  loader currently owns memory
- `ld_rdata`  out  DATA_W  registered read data for loader
- `ld_done`  out  1  one-cycle completion pulse for loader
- `mem_read`, `mem_write`  out  1  memory strobes
- `mem_addr`, `mem_wdata`  out  ADDR_W/DATA_W  memory address and write data
- `mem_rdata`  in  DATA_W  memory read data
- `busy`  out  1  state != IDLE

## Operation
- FSM states: IDLE, ACC, RESP. Owner register: CORE or LD.
- IDLE: if any request is pending at the clock edge, latch the owner and its `we`/`addr`/`wdata`, load the latency counter with MEM_LAT-1, and go to ACC. Otherwise stay in IDLE.
- Priority: core wins when both request. Exception: the loader wins when starvation is enabled and the starve count has reached STARVE_MAX.
- ACC: `mem_addr`/`mem_wdata` come from the latched request. Exactly one of `mem_read`/`mem_write` is high, per the latched `we`. The counter decrements each cycle. On the edge where the counter is 0, capture `mem_rdata` into the owner's rdata register (read accesses only; writes leave it unchanged) and go to RESP.
- RESP: the owner's `*_done` is high for this single cycle, strobes are low, and the next state is IDLE. There is no back-to-back grant from RESP; this gives one idle cycle of arbitration turnaround.
- Request fields are latched, so a requester may change or drop them after the grant edge without affecting the access. A dropped request still completes and still pulses done.
- A requester must drop or change its request in the done cycle. If `req` is still high in IDLE, it is treated as a new access.
- `ld_gnt` = (owner==LD) && state∈{ACC,RESP}.
- `core_stall` = `core_req` && !`core_done`. It is combinational and does not depend on state.
- Reset (async, any state): state=IDLE, counters=0, owner=CORE. `core_rdata`=`ld_rdata`=0. `core_done`=`ld_done`=`ld_gnt`=`mem_read`=`mem_write`=`busy`=0, `mem_addr`=`mem_wdata`=0. `core_stall` follows `core_req`.
- Reset mid-access: the strobes drop immediately and no done is issued. The requester must re-issue.

## Timing
- Request sampled at edge E0. Strobes are high for cycles 1..MEM_LAT. Done is high in cycle MEM_LAT+1. IDLE returns in cycle MEM_LAT+2.
- Access-to-access period per master is MEM_LAT+2 cycles. A losing requester waits at least one full period.
- `*_rdata` is valid from the done cycle and holds until that owner's next read completes.

## Configuration
- `MEM_ARB_STARVE_EN` defined:
  - An 8-bit starve counter increments at every IDLE grant where `ld_req`=1 but the core wins, saturating at STARVE_MAX.
  - When the count equals STARVE_MAX, the next IDLE decision grants the loader even if `core_req`=1.
  - The counter clears on every loader grant.
- `MEM_ARB_STARVE_EN` not defined: strict core priority, no counter logic. The loader is served only in IDLE cycles with `core_req`=0.

## Test plan
- MEM_LAT=1, core read of addr 0x10 with `mem_rdata`=0xDEADBEEF_00000013 -> `mem_read` high 1 cycle, `core_done` pulses in cycle 2, `core_rdata`=0xDEADBEEF_00000013, `core_stall` high cycles 0..1.
- MEM_LAT=3, loader write addr 0x40 data 0x1234 -> `mem_write` high exactly 3 cycles with addr 0x40/data 0x1234, `ld_gnt` high 4 cycles, `ld_done` in cycle 4, `ld_rdata` unchanged.
- Both request the same cycle, starve disabled -> core served first, loader granted in the IDLE after core's RESP, once `core_req` is low.
- `MEM_ARB_STARVE_EN`, STARVE_MAX=2, `core_req` and `ld_req` held high -> grant order is CORE, CORE, LD, CORE, CORE, LD.
- Assert `reset`=0 in the second ACC cycle of a MEM_LAT=3 read -> `mem_read`/`busy` drop in the same cycle without waiting for an edge, no done. After release, a re-issued read completes normally.
- Core drops `core_req` after the grant edge -> access still completes, `core_done` pulses once, FSM returns to IDLE with no second access.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master (core / loader) arbiter and fixed-latency sequencer for the shared memory port.
// Optional loader anti-starvation is enabled by defining MEM_ARB_STARVE_EN.
module mem_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_done,
    output logic              core_stall,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_done,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;
    typedef enum logic {CORE, LD} owner_t;

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    if (MEM_LAT < 1 || MEM_LAT > 15) begin : gLatRange
        $error("mem_arbiter: MEM_LAT must be within 1..15");
    end
    if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : gStarveRange
        $error("mem_arbiter: STARVE_MAX must be within 1..255");
    end

    state_t     state;
    owner_t     owner;
    logic [3:0] latCnt;
    logic       grantLd;

`ifdef MEM_ARB_STARVE_EN
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
    logic [7:0] starveCnt;
`endif

    always_comb begin
        grantLd = ld_req && !core_req;
`ifdef MEM_ARB_STARVE_EN
        grantLd = ld_req && (!core_req || starveCnt == STARVE_LIM);
`endif
    end

    // Combinational so the control unit freezes in the very cycle it requests.
    assign core_stall = core_req && !core_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= CORE;
            latCnt     <= '0;
            core_rdata <= '0;
            ld_rdata   <= '0;
            core_done  <= 1'b0;
            ld_done    <= 1'b0;
            ld_gnt     <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
`ifdef MEM_ARB_STARVE_EN
            starveCnt  <= '0;
`endif
        end else begin
            core_done <= 1'b0;
            ld_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (core_req || ld_req) begin
                        state  <= ACC;
                        busy   <= 1'b1;
                        latCnt <= LAT_LOAD;
                        ld_gnt <= grantLd;
                        if (grantLd) begin
                            owner     <= LD;
                            mem_addr  <= ld_addr;
                            mem_wdata <= ld_wdata;
                            mem_read  <= !ld_we;
                            mem_write <= ld_we;
                        end else begin
                            owner     <= CORE;
                            mem_addr  <= core_addr;
                            mem_wdata <= core_wdata;
                            mem_read  <= !core_we;
                            mem_write <= core_we;
                        end
`ifdef MEM_ARB_STARVE_EN
                        if (grantLd) begin
                            starveCnt <= '0;
                        end else if (ld_req && starveCnt < STARVE_LIM) begin
                            starveCnt <= starveCnt + 1'b1;
                        end
`endif
                    end
                end
                ACC: begin
                    if (latCnt == '0) begin
                        // Last strobe cycle: the read data is valid at this edge.
                        state     <= RESP;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (owner == LD) begin
                            ld_done <= 1'b1;
                            if (mem_read) begin
                                ld_rdata <= mem_rdata;
                            end
                        end else begin
                            core_done <= 1'b1;
                            if (mem_read) begin
                                core_rdata <= mem_rdata;
                            end
                        end
                    end else begin
                        latCnt <= latCnt - 1'b1;
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    ld_gnt <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a cycle-phase reference model.
// Honours MEM_ARB_STARVE_EN the same way as the design.
module tb_mem_arbiter;

    localparam int AW   = 64;
    localparam int DW   = 64;
    localparam int LAT  = 3;
    localparam int SMAX = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_req, core_we, ld_req, ld_we;
    logic [AW-1:0] core_addr, ld_addr, mem_addr;
    logic [DW-1:0] core_wdata, ld_wdata, mem_wdata, mem_rdata;
    logic [DW-1:0] core_rdata, ld_rdata;
    logic          core_done, core_stall, ld_gnt, ld_done;
    logic          mem_read, mem_write, busy;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rdata(core_rdata), .core_done(core_done), .core_stall(core_stall),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rdata(ld_rdata), .ld_done(ld_done),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    int errCnt = 0;
    int chkCnt = 0;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s at cycle %0d: got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: one access described by its grant cycle; outputs follow from the phase.
    bit            mActive = 1'b0;
    int            mGrantCyc = 0;
    bit            mOwnLd = 1'b0;
    bit            mWe = 1'b0;
    logic [63:0]   mAddr = '0, mWdata = '0, mCoreRd = '0, mLdRd = '0;
    int            mStarve = 0;
    int            cyc = 0;
    int            obsQ[$];

    task automatic evalCycle();
        int ph;
        bit bsy, strobe, doneC, doneL, ldWins;
        #1;
        if (!reset) begin
            mActive = 1'b0;
            mCoreRd = '0;
            mLdRd   = '0;
            mStarve = 0;
        end
        ph     = mActive ? cyc - mGrantCyc : 0;
        bsy    = mActive && ph >= 1 && ph <= LAT + 1;
        strobe = mActive && ph >= 1 && ph <= LAT;
        doneC  = mActive && ph == LAT + 1 && !mOwnLd;
        doneL  = mActive && ph == LAT + 1 && mOwnLd;

        checkVal("busy", 64'(busy), 64'(bsy));
        checkVal("mem_read", 64'(mem_read), 64'(strobe && !mWe));
        checkVal("mem_write", 64'(mem_write), 64'(strobe && mWe));
        if (strobe) begin
            checkVal("mem_addr", mem_addr, mAddr);
            checkVal("mem_wdata", mem_wdata, mWdata);
        end
        if (!reset) begin
            checkVal("rst_mem_addr", mem_addr, 64'h0);
            checkVal("rst_mem_wdata", mem_wdata, 64'h0);
        end
        checkVal("core_done", 64'(core_done), 64'(doneC));
        checkVal("ld_done", 64'(ld_done), 64'(doneL));
        checkVal("ld_gnt", 64'(ld_gnt), 64'(bsy && mOwnLd));
        checkVal("core_stall", 64'(core_stall), 64'(core_req && !doneC));
        checkVal("core_rdata", core_rdata, mCoreRd);
        checkVal("ld_rdata", ld_rdata, mLdRd);

        if (core_done) obsQ.push_back(0);
        if (ld_done) obsQ.push_back(1);

        if (reset) begin
            if (strobe && ph == LAT && !mWe) begin
                if (mOwnLd) mLdRd = mem_rdata;
                else mCoreRd = mem_rdata;
            end
            if (!bsy && (core_req || ld_req)) begin
`ifdef MEM_ARB_STARVE_EN
                ldWins = ld_req && (!core_req || mStarve == SMAX);
                if (ldWins) mStarve = 0;
                else if (ld_req && mStarve < SMAX) mStarve++;
`else
                ldWins = ld_req && !core_req;
`endif
                mActive   = 1'b1;
                mGrantCyc = cyc;
                mOwnLd    = ldWins;
                mWe       = ldWins ? ld_we : core_we;
                mAddr     = ldWins ? ld_addr : core_addr;
                mWdata    = ldWins ? ld_wdata : core_wdata;
            end
        end
        cyc++;
    endtask

    task automatic step(input bit rs, input bit cr, input bit cw, input logic [63:0] ca,
                        input logic [63:0] cd, input bit lr, input bit lw, input logic [63:0] la,
                        input logic [63:0] ldd, input logic [63:0] mr);
        @(negedge clk);
        reset      = rs;
        core_req   = cr;
        core_we    = cw;
        core_addr  = ca;
        core_wdata = cd;
        ld_req     = lr;
        ld_we      = lw;
        ld_addr    = la;
        ld_wdata   = ldd;
        mem_rdata  = mr;
        evalCycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 64'h5A5A);
    endtask

    task automatic doReset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b0; core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
        ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0; mem_rdata = '0;

        // Reset state, with core_stall following core_req while in reset
        step(0, 1, 0, 64'h10, 0, 1, 0, 64'h20, 0, 64'h77);
        checkVal("rst_busy", 64'(busy), 64'h0);
        checkVal("rst_stall", 64'(core_stall), 64'h1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Core read of 0x10, request held through the strobes, dropped in the done cycle
        obsQ.delete();
        for (int i = 0; i < 4; i++) step(1, 1, 0, 64'h10, 0, 0, 0, 0, 0, 64'hDEADBEEF_00000013);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 64'h1111);
        checkVal("rd10_data", core_rdata, 64'hDEADBEEF_00000013);
        idle(2);
        checkVal("rd10_ndone", 64'(obsQ.size()), 64'd1);

        // Loader write of 0x1234 to 0x40; loader read data must stay untouched
        obsQ.delete();
        step(1, 0, 0, 0, 0, 1, 1, 64'h40, 64'h1234, 64'h9999);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1, 1, 64'h40, 64'h1234, 64'h9999);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 64'h9999);
        checkVal("ldw_rdata", ld_rdata, 64'h0);
        idle(2);
        checkVal("ldw_order", 64'(obsQ.size() == 1 && obsQ[0] == 1), 64'd1);

        // Both request together: core first, loader after the turnaround cycle
        obsQ.delete();
        for (int i = 0; i < 4; i++) step(1, 1, 0, 64'h100, 0, 1, 0, 64'h200, 0, 64'hAAAA);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 1, 0, 64'h200, 0, 64'hBBBB);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 64'hCCCC);
        idle(2);
        checkVal("both_n", 64'(obsQ.size()), 64'd2);
        if (obsQ.size() == 2) begin
            checkVal("both_first", 64'(obsQ[0]), 64'd0);
            checkVal("both_second", 64'(obsQ[1]), 64'd1);
        end
        checkVal("both_ldrd", ld_rdata, 64'hBBBB);

        // Both held high for six periods
        doReset();
        obsQ.delete();
        for (int i = 0; i < 30; i++) step(1, 1, 0, 64'h300, 0, 1, 0, 64'h400, 0, 64'(i));
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        checkVal("hold_n", 64'(obsQ.size()), 64'd6);
        if (obsQ.size() == 6) begin
`ifdef MEM_ARB_STARVE_EN
            for (int i = 0; i < 6; i++) checkVal("starve_order", 64'(obsQ[i]), 64'((i % 3) == 2));
`else
            for (int i = 0; i < 6; i++) checkVal("strict_order", 64'(obsQ[i]), 64'd0);
`endif
        end

        // Asynchronous reset in the second strobe cycle, then a re-issued read
        obsQ.delete();
        step(1, 1, 0, 64'h500, 0, 0, 0, 0, 0, 64'hE0);
        step(1, 1, 0, 64'h500, 0, 0, 0, 0, 0, 64'hE1);
        step(0, 1, 0, 64'h500, 0, 0, 0, 0, 0, 64'hE2);
        checkVal("rstmid_read", 64'(mem_read), 64'h0);
        checkVal("rstmid_busy", 64'(busy), 64'h0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 64'hE3);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 64'hE4);
        checkVal("rstmid_nodone", 64'(obsQ.size()), 64'd0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 64'h500, 0, 0, 0, 0, 0, 64'hF00D);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0);
        checkVal("reissue_data", core_rdata, 64'hF00D);
        checkVal("reissue_n", 64'(obsQ.size()), 64'd1);

        // Core drops its request right after the grant edge
        obsQ.delete();
        step(1, 1, 0, 64'h600, 0, 0, 0, 0, 0, 64'h6666);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 64'h6666);
        checkVal("drop_n", 64'(obsQ.size()), 64'd1);
        checkVal("drop_data", core_rdata, 64'h6666);
        checkVal("drop_busy", 64'(busy), 64'h0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 2) != 0), 1'($urandom), 64'({$urandom, $urandom}),
                 64'({$urandom, $urandom}),
                 ($urandom_range(0, 2) != 0), 1'($urandom), 64'({$urandom, $urandom}),
                 64'({$urandom, $urandom}), 64'({$urandom, $urandom}));
        end

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
